// File: rtl/seq_lock_pkg.sv
// Shared types for the two-button sequential lock: state encodings and
// a helper for sizing the shared cycle timer.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_press.sv
// Turns the two debounced button levels into single-cycle press pulses.
// A press needs an all-released sample before it; 11 is never a press.
module btn_press (
  input  logic clk,
  input  logic rst,
  input  logic b0,
  input  logic b1,
  output logic p0,
  output logic p1
);

  logic [1:0] prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 2'b00;
    else      prev <= {b1, b0};
  end

  assign p0 = (prev == 2'b00) && ({b1, b0} == 2'b01);
  assign p1 = (prev == 2'b00) && ({b1, b0} == 2'b10);

endmodule

// File: rtl/seq_lock.sv
// Parametrised two-button combination lock with fail counting, timed
// lockout, bounded unlock window and an inactivity timeout on partial entries.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for the first digit of an entry
//   ENTRY    | collecting digits; timer guards against a stalled entry
//   UNLOCKED | unlock high until the timer expires or any press
//   LOCKOUT  | too many wrong entries; presses ignored until timer expires
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] CODE           = 5'b10010,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  LOCKOUT_CYCLES = 16,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  TIMEOUT_CYCLES = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             b0,
  input  logic                             b1,
  output logic                             unlock,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
  output logic [1:0]                       debugstate
);

  localparam int TMAX = max3(LOCKOUT_CYCLES, UNLOCK_CYCLES, TIMEOUT_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);

  // The single timer counts down to zero; each state loads its length minus one
  // so the terminal-count edge is exactly N cycles after the load edge.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNL_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

  state_t              state;
  logic [TW-1:0]       tmr;
  logic [CODE_LEN-1:0] shreg;
  logic [CODE_LEN-1:0] entry_next;
  logic                p0, p1, press;
  logic                digit_last, fails_last;

  btn_press u_btn (
    .clk (clk),
    .rst (rst),
    .b0  (b0),
    .b1  (b1),
    .p0  (p0),
    .p1  (p1)
  );

  assign press      = p0 | p1;
  assign entry_next = {shreg[CODE_LEN-2:0], p1};
  assign digit_last = (int'(digit_cnt) == CODE_LEN - 1);
  assign fails_last = (int'(fail_cnt) + 1 >= MAX_FAILS);
  assign debugstate = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      shreg      <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            shreg     <= {{(CODE_LEN-1){1'b0}}, p1};
            digit_cnt <= 1;
            tmr       <= TMO_LOAD;
            state     <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          // A press on the expiry edge wins over the timeout.
          if (press) begin
            shreg <= entry_next;
            tmr   <= TMO_LOAD;
            if (digit_last) begin
              digit_cnt <= '0;
              if (entry_next == CODE) begin
                state    <= ST_UNLOCKED;
                unlock   <= 1'b1;
                fail_cnt <= '0;
                tmr      <= UNL_LOAD;
              end else if (fails_last) begin
                state      <= ST_LOCKOUT;
                locked_out <= 1'b1;
                fail_cnt   <= FW'(MAX_FAILS);
                tmr        <= LCK_LOAD;
              end else begin
                state    <= ST_IDLE;
                fail_cnt <= fail_cnt + 1'b1;
              end
            end else begin
              digit_cnt <= digit_cnt + 1'b1;
            end
          end else if (tmr == '0) begin
            state     <= ST_IDLE;
            digit_cnt <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_UNLOCKED: begin
          if (press || tmr == '0) begin
            state <= ST_IDLE;
          end else begin
            unlock <= 1'b1;
            tmr    <= tmr - 1'b1;
          end
        end

        ST_LOCKOUT: begin
          if (tmr == '0) begin
            state    <= ST_IDLE;
            fail_cnt <= '0;
          end else begin
            locked_out <= 1'b1;
            tmr        <= tmr - 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_lock.sv
// Bench for seq_lock: default 5-digit instance plus an 8-digit instance
// sharing the same button stimulus.
module tb_seq_lock;
  import seq_lock_pkg::*;

  logic       clk;
  logic       rst;
  logic       b0, b1;
  logic       unlock_a, lo_a;
  logic [1:0] fc_a;
  logic [2:0] dc_a;
  logic [1:0] dbg_a;
  logic       unlock_b, lo_b;
  logic [1:0] fc_b;
  logic [3:0] dc_b;
  logic [1:0] dbg_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string  tag;
    state_t st;
    int     dc;
    int     fc;
  } exp_t;

  exp_t sb_q[$];

  seq_lock u_a (
    .clk(clk), .rst(rst), .b0(b0), .b1(b1),
    .unlock(unlock_a), .locked_out(lo_a), .fail_cnt(fc_a),
    .digit_cnt(dc_a), .debugstate(dbg_a)
  );

  seq_lock #(.CODE_LEN(8), .CODE(8'hA5)) u_b (
    .clk(clk), .rst(rst), .b0(b0), .b1(b1),
    .unlock(unlock_b), .locked_out(lo_b), .fail_cnt(fc_b),
    .digit_cnt(dc_b), .debugstate(dbg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, return 1ns after the following rising edge.
  task automatic step(input logic v1, input logic v0);
    @(negedge clk);
    b1 = v1;
    b0 = v0;
    @(posedge clk);
    #1;
  endtask

  task automatic rel();
    step(1'b0, 1'b0);
  endtask

  // One press edge: expected result queued with the stimulus, popped once the
  // edge has been taken and compared against the selected instance.
  task automatic press(input int sel, input logic d, input state_t est,
                       input int edc, input int efc, input string tag);
    exp_t       e;
    logic [1:0] ost;
    int         odc, ofc;
    e.tag = tag; e.st = est; e.dc = edc; e.fc = efc;
    sb_q.push_back(e);
    step(d, ~d);
    e   = sb_q.pop_front();
    ost = (sel != 0) ? dbg_b : dbg_a;
    odc = (sel != 0) ? int'(dc_b) : int'(dc_a);
    ofc = (sel != 0) ? int'(fc_b) : int'(fc_a);
    checks++;
    if (ost !== e.st) begin
      errors++;
      $display("FAIL %s state: got %0d want %0d", e.tag, ost, e.st);
    end
    checks++;
    if (odc !== e.dc) begin
      errors++;
      $display("FAIL %s digit_cnt: got %0d want %0d", e.tag, odc, e.dc);
    end
    checks++;
    if (ofc !== e.fc) begin
      errors++;
      $display("FAIL %s fail_cnt: got %0d want %0d", e.tag, ofc, e.fc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; b0 = 1'b0; b1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({unlock_a, lo_a, fc_a, dc_a, dbg_a} !== 9'd0) begin
      errors++;
      $display("FAIL reset_a outputs: got %b want 0", {unlock_a, lo_a, fc_a, dc_a, dbg_a});
    end
    checks++;
    if ({unlock_b, lo_b, fc_b, dc_b, dbg_b} !== 10'd0) begin
      errors++;
      $display("FAIL reset_b outputs: got %b want 0", {unlock_b, lo_b, fc_b, dc_b, dbg_b});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_correct();
    logic [4:0] code = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      press(0, code[4-i], (i < 4) ? ST_ENTRY : ST_UNLOCKED, (i < 4) ? i + 1 : 0, 0, "correct");
      if (i < 4) rel();
    end
    for (int j = 0; j < 10; j++) begin
      if (j > 0) rel();
      checks++;
      if (unlock_a !== (j < 8)) begin
        errors++;
        $display("FAIL unlock_window cycle %0d: got %b want %b", j, unlock_a, (j < 8));
      end
    end
    checks++;
    if (dbg_a !== ST_IDLE) begin
      errors++;
      $display("FAIL unlock_expiry state: got %0d want %0d", dbg_a, ST_IDLE);
    end
  endtask

  task automatic test_hold();
    press(0, 1'b1, ST_ENTRY, 1, 0, "hold_first");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    checks++;
    if (dc_a !== 3'd1) begin
      errors++;
      $display("FAIL hold digit_cnt: got %0d want 1", dc_a);
    end
    rel();
    press(0, 1'b0, ST_ENTRY, 2, 0, "hold_d2");
    rel();
    press(0, 1'b0, ST_ENTRY, 3, 0, "hold_d3");
    rel();
    step(1'b1, 1'b1);
    checks++;
    if (dc_a !== 3'd3) begin
      errors++;
      $display("FAIL both_buttons digit_cnt: got %0d want 3", dc_a);
    end
    rel();
    press(0, 1'b1, ST_ENTRY, 4, 0, "hold_d4");
    rel();
    press(0, 1'b0, ST_UNLOCKED, 0, 0, "hold_d5");
    for (int j = 0; j < 8; j++) rel();
    checks++;
    if (dbg_a !== ST_IDLE || unlock_a !== 1'b0) begin
      errors++;
      $display("FAIL hold_expiry: got state %0d unlock %b want 0 0", dbg_a, unlock_a);
    end
  endtask

  task automatic test_lockout();
    logic [4:0] code = 5'b10010;
    logic       d, v1, v0;
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 5; i++) begin
        if (i < 4)
          press(0, 1'b1, ST_ENTRY, i + 1, e, "wrong_entry");
        else
          press(0, 1'b1, (e < 2) ? ST_IDLE : ST_LOCKOUT, 0, e + 1, "wrong_last");
        if (!(e == 2 && i == 4)) rel();
      end
    end
    checks++;
    if (lo_a !== 1'b1) begin
      errors++;
      $display("FAIL lockout_start: got %b want 1", lo_a);
    end
    for (int j = 1; j <= 16; j++) begin
      v1 = 1'b0; v0 = 1'b0;
      if (j == 16) begin
        v0 = 1'b1;
      end else if ((j % 2) == 1 && j < 10) begin
        d  = code[4-(j-1)/2];
        v1 = d;
        v0 = ~d;
      end
      step(v1, v0);
      checks++;
      if (lo_a !== (j < 16) || unlock_a !== 1'b0) begin
        errors++;
        $display("FAIL lockout cycle %0d: got locked_out %b unlock %b want %b 0",
                 j, lo_a, unlock_a, (j < 16));
      end
    end
    checks++;
    if (dbg_a !== ST_IDLE || fc_a !== 2'd0 || dc_a !== 3'd0) begin
      errors++;
      $display("FAIL lockout_exit: got state %0d fail %0d digit %0d want 0 0 0", dbg_a, fc_a, dc_a);
    end
    rel();
  endtask

  task automatic test_timeout();
    logic [4:0] code = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      press(0, 1'b1, (i < 4) ? ST_ENTRY : ST_IDLE, (i < 4) ? i + 1 : 0, (i < 4) ? 0 : 1, "pre_fail");
      rel();
    end
    press(0, 1'b1, ST_ENTRY, 1, 1, "tmo_d1");
    for (int j = 0; j < 31; j++) rel();
    press(0, 1'b0, ST_ENTRY, 2, 1, "tmo_edge_press");
    for (int j = 0; j < 31; j++) rel();
    checks++;
    if (dbg_a !== ST_ENTRY || dc_a !== 3'd2) begin
      errors++;
      $display("FAIL tmo_before: got state %0d digit %0d want 1 2", dbg_a, dc_a);
    end
    rel();
    checks++;
    if (dbg_a !== ST_IDLE || dc_a !== 3'd0 || fc_a !== 2'd1) begin
      errors++;
      $display("FAIL tmo_expire: got state %0d digit %0d fail %0d want 0 0 1", dbg_a, dc_a, fc_a);
    end
    for (int i = 0; i < 5; i++) begin
      press(0, code[4-i], (i < 4) ? ST_ENTRY : ST_UNLOCKED, (i < 4) ? i + 1 : 0,
            (i < 4) ? 1 : 0, "tmo_then_code");
      rel();
    end
    for (int j = 0; j < 8; j++) rel();
  endtask

  task automatic test_relock_reset();
    logic [4:0] code = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      press(0, code[4-i], (i < 4) ? ST_ENTRY : ST_UNLOCKED, (i < 4) ? i + 1 : 0, 0, "relock_code");
      if (i < 4) rel();
    end
    rel();
    rel();
    press(0, 1'b0, ST_IDLE, 0, 0, "relock_press");
    checks++;
    if (unlock_a !== 1'b0) begin
      errors++;
      $display("FAIL relock unlock: got %b want 0", unlock_a);
    end
    rel();
    press(0, 1'b1, ST_ENTRY, 1, 0, "rst_d1");
    rel();
    press(0, 1'b0, ST_ENTRY, 2, 0, "rst_d2");
    rel();
    press(0, 1'b0, ST_ENTRY, 3, 0, "rst_d3");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({unlock_a, lo_a, fc_a, dc_a, dbg_a} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset outputs: got %b want 0", {unlock_a, lo_a, fc_a, dc_a, dbg_a});
    end
    @(negedge clk);
    b0 = 1'b0; b1 = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_param();
    logic [7:0] good = 8'hA5;
    logic [7:0] bad  = 8'hA4;
    @(negedge clk);
    rst = 1'b0; b0 = 1'b0; b1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      press(1, good[7-i], (i < 7) ? ST_ENTRY : ST_UNLOCKED, (i < 7) ? i + 1 : 0, 0, "p8_good");
      if (i < 7) rel();
    end
    checks++;
    if (unlock_b !== 1'b1) begin
      errors++;
      $display("FAIL p8_unlock: got %b want 1", unlock_b);
    end
    for (int j = 0; j < 8; j++) rel();
    for (int i = 0; i < 8; i++) begin
      press(1, bad[7-i], (i < 7) ? ST_ENTRY : ST_IDLE, (i < 7) ? i + 1 : 0, (i < 7) ? 0 : 1, "p8_bad");
      rel();
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_hold();
    test_lockout();
    test_timeout();
    test_relock_reset();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
